// File: rtl/regfile_read_port.sv
// regfile_read_port: NREGS x WIDTH register file with a single load-style write
// port and a dual-operand read port.
// Reads use a req/valid/ack handshake. The read data outputs are registered.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// to a read that targets the same address.
module regfile_read_port #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned NREGS    = 16,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_req,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic             rd_ready,
    output logic             rd_valid,
    input  logic             rd_ack,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0] rd_data_a_q, rd_data_a_d;
    logic [WIDTH-1:0] rd_data_b_q, rd_data_b_d;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    logic             wr_ok;
    logic             capture;
    logic [WIDTH-1:0] val_a;
    logic [WIDTH-1:0] val_b;

    // Address is backed by storage and is not the hardwired zero register
    function automatic logic addr_writable(input logic [AW-1:0] addr);
        logic ok;
        ok = (32'(addr) < NREGS);
        if (ZERO_REG && (addr == '0)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    // Stored value of a register; out-of-range and hardwired-zero addresses read 0
    function automatic logic [WIDTH-1:0] reg_value(input logic [AW-1:0] addr);
        logic [WIDTH-1:0] v;
        v = '0;
        if (addr_writable(addr)) begin
            v = regs_q[addr];
        end
        return v;
    endfunction

    // Handshake qualification: a request is taken when idle or when the held read is acked
    always_comb begin
        rd_ready = (state_q == IDLE) | rd_ack;
        capture  = rd_req & rd_ready;
        wr_ok    = load & addr_writable(wr_addr);
    end

    // Next storage contents from the write port
    always_comb begin
        for (int unsigned i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_ok) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    // Operand lookup, with optional same-cycle write forwarding per operand
    always_comb begin
        val_a = reg_value(rd_addr_a);
        val_b = reg_value(rd_addr_b);
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (wr_addr == rd_addr_a)) begin
            val_a = wr_data;
        end
        if (wr_ok && (wr_addr == rd_addr_b)) begin
            val_b = wr_data;
        end
`endif
    end

    // Read FSM next state and registered output values
    always_comb begin
        state_d     = state_q;
        rd_valid_d  = rd_valid_q;
        rd_data_a_d = rd_data_a_q;
        rd_data_b_d = rd_data_b_q;
        unique case (state_q)
            IDLE: begin
                if (rd_req) begin
                    state_d = VALID;
                end
            end
            VALID: begin
                if (rd_ack && !rd_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        rd_valid_d = (state_d == VALID);
        if (capture) begin
            rd_data_a_d = val_a;
            rd_data_b_d = val_b;
        end
    end

    // Storage registers, cleared asynchronously
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read FSM state and registered outputs, cleared asynchronously
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q     <= IDLE;
            rd_valid_q  <= 1'b0;
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
        end else begin
            state_q     <= state_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_a_q <= rd_data_a_d;
            rd_data_b_q <= rd_data_b_d;
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_data_a = rd_data_a_q;
    assign rd_data_b = rd_data_b_q;

endmodule

// File: tb/tb_regfile_read_port.sv
// Directed self-checking bench for regfile_read_port (default parameters).
module tb_regfile_read_port;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned NREGS = 16;
    localparam int unsigned AW    = 4;

`ifdef REGFILE_BYPASS_EN
    localparam logic [31:0] SAME_CYCLE_EXP = 32'd2;
`else
    localparam logic [31:0] SAME_CYCLE_EXP = 32'd1;
`endif

    logic             clock = 1'b0;
    logic             clear;
    logic             load;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             rd_req;
    logic [AW-1:0]    rd_addr_a;
    logic [AW-1:0]    rd_addr_b;
    logic             rd_ready;
    logic             rd_valid;
    logic             rd_ack;
    logic [WIDTH-1:0] rd_data_a;
    logic [WIDTH-1:0] rd_data_b;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_read_port #(
        .WIDTH    (WIDTH),
        .NREGS    (NREGS),
        .ZERO_REG (1'b1)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .load      (load),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_req    (rd_req),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_ack    (rd_ack),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_reg(input logic [AW-1:0] a, input logic [31:0] d);
        load    = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        load    = 1'b0;
    endtask

    task automatic start_read(input logic [AW-1:0] a, input logic [AW-1:0] b);
        rd_req    = 1'b1;
        rd_addr_a = a;
        rd_addr_b = b;
        tick();
        rd_req    = 1'b0;
    endtask

    task automatic ack_read();
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        clear     = 1'b1;
        load      = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_req    = 1'b0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        rd_ack    = 1'b0;
        tick();
        tick();
        clear = 1'b0;
        tick();

        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_ready", 32'(rd_ready), 32'd1);
        check("rst_data_a", rd_data_a, 32'd0);
        check("rst_data_b", rd_data_b, 32'd0);

        // Basic read with one-cycle latency
        write_reg(4'd5, 32'h1234_5678);
        write_reg(4'd9, 32'hCAFE_0001);
        start_read(4'd5, 4'd9);
        check("basic_valid", 32'(rd_valid), 32'd1);
        check("basic_a", rd_data_a, 32'h1234_5678);
        check("basic_b", rd_data_b, 32'hCAFE_0001);
        check("basic_ready_held", 32'(rd_ready), 32'd0);

        // Backpressure: requests with new addresses are ignored while unacked
        for (int i = 0; i < 4; i++) begin
            rd_req    = 1'b1;
            rd_addr_a = 4'd9;
            rd_addr_b = 4'd5;
            #1;
            check("hold_ready", 32'(rd_ready), 32'd0);
            tick();
            check("hold_valid", 32'(rd_valid), 32'd1);
            check("hold_a", rd_data_a, 32'h1234_5678);
            check("hold_b", rd_data_b, 32'hCAFE_0001);
        end
        rd_req = 1'b0;

        // Back-to-back reads, one per cycle
        write_reg(4'd1, 32'd11);
        write_reg(4'd2, 32'd22);
        write_reg(4'd3, 32'd33);
        rd_ack = 1'b1;
        rd_req = 1'b1;
        rd_addr_a = 4'd1; rd_addr_b = 4'd2;
        tick();
        check("b2b_valid1", 32'(rd_valid), 32'd1);
        check("b2b_a1", rd_data_a, 32'd11);
        check("b2b_b1", rd_data_b, 32'd22);
        rd_addr_a = 4'd2; rd_addr_b = 4'd3;
        tick();
        check("b2b_valid2", 32'(rd_valid), 32'd1);
        check("b2b_a2", rd_data_a, 32'd22);
        check("b2b_b2", rd_data_b, 32'd33);
        rd_addr_a = 4'd3; rd_addr_b = 4'd3;
        tick();
        check("b2b_valid3", 32'(rd_valid), 32'd1);
        check("b2b_a3", rd_data_a, 32'd33);
        check("b2b_b3", rd_data_b, 32'd33);
        rd_req = 1'b0;
        tick();
        rd_ack = 1'b0;
        check("b2b_drain_valid", 32'(rd_valid), 32'd0);
        check("b2b_drain_ready", 32'(rd_ready), 32'd1);

        // Ack while idle has no effect
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        check("idle_ack_valid", 32'(rd_valid), 32'd0);

        // Zero register and top register
        write_reg(4'd0, 32'hFFFF_FFFF);
        write_reg(4'd15, 32'd7);
        start_read(4'd0, 4'd15);
        check("zero_a", rd_data_a, 32'd0);
        check("top_b", rd_data_b, 32'd7);
        ack_read();

        // Same-cycle write and read of r4
        write_reg(4'd4, 32'd1);
        load      = 1'b1;
        wr_addr   = 4'd4;
        wr_data   = 32'd2;
        rd_req    = 1'b1;
        rd_addr_a = 4'd4;
        rd_addr_b = 4'd4;
        tick();
        load   = 1'b0;
        rd_req = 1'b0;
        check("same_cycle_a", rd_data_a, SAME_CYCLE_EXP);
        check("same_cycle_b", rd_data_b, SAME_CYCLE_EXP);
        ack_read();
        start_read(4'd4, 4'd5);
        check("after_write_a", rd_data_a, 32'd2);
        check("after_write_b", rd_data_b, 32'h1234_5678);
        ack_read();

        // Asynchronous clear during a held read
        write_reg(4'd3, 32'hDEAD_BEEF);
        start_read(4'd3, 4'd3);
        check("pre_clear_valid", 32'(rd_valid), 32'd1);
        check("pre_clear_a", rd_data_a, 32'hDEAD_BEEF);
        #2;
        clear = 1'b1;
        #1;
        check("clear_valid", 32'(rd_valid), 32'd0);
        check("clear_ready", 32'(rd_ready), 32'd1);
        check("clear_a", rd_data_a, 32'd0);
        check("clear_b", rd_data_b, 32'd0);
        tick();
        clear = 1'b0;
        start_read(4'd3, 4'd5);
        check("post_clear_r3", rd_data_a, 32'd0);
        check("post_clear_r5", rd_data_b, 32'd0);
        ack_read();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
